cvxif_issue_arbiter: RTL and testbench

//  Shares one CV-X-IF coprocessor between NumReq issuing cores.
//  - Arbitrates issue requests round-robin and tags each forwarded instruction

---
 rtl/cvxif_issue_arbiter.sv | 149 ++++++++++++++
 tb/tb_cvxif_issue_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_issue_arbiter.sv
// Round-robin issue arbiter sharing one CV-X-IF coprocessor between NumReq cores,
// with per-requester write-back tracking and result routing by requester tag.
module cvxif_issue_arbiter #(
  parameter int NumReq         = 2,
  parameter int IdWidth        = 3,
  parameter int InstrWidth     = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  logic [NumReq*InstrWidth-1:0]        req_instr_i,
  input  logic [NumReq*IdWidth-1:0]           req_id_i,
  output logic                                req_accept_o,
  output logic                                req_wb_o,
  output logic [NumReq-1:0]                   res_valid_o,
  output logic [IdWidth-1:0]                  res_id_o,
  output logic [DataWidth-1:0]                res_data_o,
  output logic                                cop_valid_o,
  input  logic                                cop_ready_i,
  output logic [InstrWidth-1:0]               cop_instr_o,
  output logic [$clog2(NumReq)+IdWidth-1:0]   cop_id_o,
  input  logic                                cop_accept_i,
  input  logic                                cop_wb_i,
  input  logic                                cop_res_valid_i,
  input  logic [$clog2(NumReq)+IdWidth-1:0]   cop_res_id_i,
  input  logic [DataWidth-1:0]                cop_res_data_i,
  output logic                                err_o
);

  localparam int IdxW   = $clog2(NumReq);
  localparam int CntW   = $clog2(MaxOutstanding + 1);
  localparam int CopIdW = IdxW + IdWidth;

  logic [IdxW-1:0] rr_ptr_p0;
  logic            lock_p0;
  logic [IdxW-1:0] lock_idx_p0;
  logic            err_p0;
  logic [CntW-1:0] cnt_p0 [NumReq];

  logic [NumReq-1:0] elig;
  logic [IdxW-1:0]   rr_idx;
  logic              rr_found;
  int                cand;
  logic [IdxW-1:0]   grant_idx;
  logic              grant_vld;
  logic              hs;
  logic              cnt_inc;
  logic [IdxW-1:0]   grant_next;

  logic [IdxW-1:0]   res_idx;
  logic [NumReq-1:0] res_hit;
  logic [NumReq-1:0] res_ok;
  logic [NumReq-1:0] inc_vec;
  logic              res_bad;

  // Eligibility: a requester at its outstanding limit is masked from arbitration.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] && (cnt_p0[i] < CntW'(MaxOutstanding));
    end
  end

  // Scan offsets from the far end so the candidate closest to the pointer wins.
  always_comb begin
    rr_idx   = rr_ptr_p0;
    rr_found = 1'b0;
    cand     = 0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_p0) + k) % NumReq;
      if (elig[cand]) begin
        rr_idx   = IdxW'(cand);
        rr_found = 1'b1;
      end
    end
  end

  // A stalled grant is held on its requester; if it withdraws, the lock releases.
  assign grant_idx = lock_p0 ? lock_idx_p0 : rr_idx;
  assign grant_vld = !rst_i && (lock_p0 ? elig[lock_idx_p0] : rr_found);
  assign hs        = grant_vld && cop_ready_i;
  assign cnt_inc   = hs && cop_accept_i && cop_wb_i;
  assign grant_next = (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + IdxW'(1);

  assign cop_valid_o  = grant_vld;
  assign cop_instr_o  = req_instr_i[grant_idx*InstrWidth +: InstrWidth];
  assign cop_id_o     = {grant_idx, req_id_i[grant_idx*IdWidth +: IdWidth]};
  assign req_accept_o = cop_accept_i;
  assign req_wb_o     = cop_wb_i;

  always_comb begin
    req_ready_o = '0;
    if (grant_vld) begin
      req_ready_o[grant_idx] = cop_ready_i;
    end
  end

  // Result routing: the upper id bits select the requester; unmatched or
  // unexpected results are dropped and flagged.
  assign res_idx = cop_res_id_i[CopIdW-1:IdWidth];

  for (genvar g = 0; g < NumReq; g++) begin : g_req
    assign res_hit[g] = !rst_i && cop_res_valid_i && (res_idx == IdxW'(g));
    assign res_ok[g]  = res_hit[g] && (cnt_p0[g] != '0);
    assign inc_vec[g] = cnt_inc && (grant_idx == IdxW'(g));
  end

  assign res_bad     = !rst_i && cop_res_valid_i && !(|res_ok);
  assign res_valid_o = res_ok;
  assign res_id_o    = cop_res_id_i[IdWidth-1:0];
  assign res_data_o  = cop_res_data_i;
  assign err_o       = err_p0;

  // Stage p0: arbitration state, outstanding counters and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_p0   <= '0;
      lock_p0     <= 1'b0;
      lock_idx_p0 <= '0;
      err_p0      <= 1'b0;
      for (int i = 0; i < NumReq; i++) begin
        cnt_p0[i] <= '0;
      end
    end else begin
      if (hs) begin
        rr_ptr_p0 <= grant_next;
        lock_p0   <= 1'b0;
      end else if (grant_vld) begin
        lock_p0     <= 1'b1;
        lock_idx_p0 <= grant_idx;
      end else begin
        lock_p0 <= 1'b0;
      end
      if (res_bad) begin
        err_p0 <= 1'b1;
      end
      for (int i = 0; i < NumReq; i++) begin
        if (inc_vec[i] && !res_ok[i]) begin
          cnt_p0[i] <= cnt_p0[i] + CntW'(1);
        end else if (res_ok[i] && !inc_vec[i]) begin
          cnt_p0[i] <= cnt_p0[i] - CntW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// Scoreboard bench for cvxif_issue_arbiter: directed stimulus pushes expected
// issues/results; a negedge monitor pops and compares on each DUT output.
module tb_cvxif_issue_arbiter;

  localparam int NumReq = 2;
  localparam int IdWidth = 3;
  localparam int InstrWidth = 32;
  localparam int DataWidth = 64;
  localparam int MaxOutstanding = 4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] instr;
  } iss_t;

  typedef struct packed {
    logic [1:0]  vld;
    logic [2:0]  id;
    logic [63:0] data;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_instr;
  logic [5:0]  req_id;
  logic        req_accept;
  logic        req_wb;
  logic [1:0]  res_valid;
  logic [2:0]  res_id;
  logic [63:0] res_data;
  logic        cop_valid;
  logic        cop_ready;
  logic [31:0] cop_instr;
  logic [3:0]  cop_id;
  logic        cop_accept;
  logic        cop_wb;
  logic        cop_res_valid;
  logic [3:0]  cop_res_id;
  logic [63:0] cop_res_data;
  logic        err;

  int n_tests = 0;
  int n_fail = 0;
  iss_t exp_iss[$];
  res_t exp_res[$];
  iss_t e_iss;
  res_t e_res;

  always #5 clk = ~clk;

  cvxif_issue_arbiter #(
    .NumReq(NumReq), .IdWidth(IdWidth), .InstrWidth(InstrWidth),
    .DataWidth(DataWidth), .MaxOutstanding(MaxOutstanding)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_instr_i(req_instr), .req_id_i(req_id),
    .req_accept_o(req_accept), .req_wb_o(req_wb),
    .res_valid_o(res_valid), .res_id_o(res_id), .res_data_o(res_data),
    .cop_valid_o(cop_valid), .cop_ready_i(cop_ready),
    .cop_instr_o(cop_instr), .cop_id_o(cop_id),
    .cop_accept_i(cop_accept), .cop_wb_i(cop_wb),
    .cop_res_valid_i(cop_res_valid), .cop_res_id_i(cop_res_id),
    .cop_res_data_i(cop_res_data), .err_o(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] instr, input logic [2:0] id);
    req_instr[idx*32 +: 32] = instr;
    req_id[idx*3 +: 3]      = id;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && cop_valid && cop_ready) begin
      if (exp_iss.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_issue: got id %0h instr %0h, none expected", cop_id, cop_instr);
      end else begin
        e_iss = exp_iss.pop_front();
        check("issue_id", {60'd0, cop_id}, {60'd0, e_iss.id});
        check("issue_instr", {32'd0, cop_instr}, {32'd0, e_iss.instr});
      end
    end
    if (!rst && (res_valid != 2'b00)) begin
      if (exp_res.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got res_valid %0h id %0h, none expected", res_valid, res_id);
      end else begin
        e_res = exp_res.pop_front();
        check("res_valid", {62'd0, res_valid}, {62'd0, e_res.vld});
        check("res_id", {61'd0, res_id}, {61'd0, e_res.id});
        check("res_data", res_data, e_res.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_instr = '0;
    req_id = '0;
    cop_ready = 1'b1;
    cop_accept = 1'b1;
    cop_wb = 1'b0;
    cop_res_valid = 1'b1;
    cop_res_id = 4'b1000;
    cop_res_data = '0;

    // Reset: nothing issued, nothing returned, no error even with a result present.
    next_cycle();
    @(negedge clk);
    check("rst_ready", {62'd0, req_ready}, 64'd0);
    check("rst_cop_valid", {63'd0, cop_valid}, 64'd0);
    check("rst_res_valid", {62'd0, res_valid}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    next_cycle();
    rst = 1'b0;
    req_valid = 2'b00;
    cop_res_valid = 1'b0;

    // 1. Single requester.
    req_valid = 2'b01;
    set_req(0, 32'hA000_0000, 3'd5);
    exp_iss.push_back('{id: 4'b0101, instr: 32'hA000_0000});
    @(negedge clk);
    check("t1_ready", {62'd0, req_ready}, 64'h1);
    check("t1_accept", {63'd0, req_accept}, 64'h1);
    check("t1_wb", {63'd0, req_wb}, 64'h0);
    next_cycle();

    // Pointer returns to 0 through reset.
    rst = 1'b1;
    req_valid = 2'b00;
    next_cycle();
    rst = 1'b0;

    // 2. Fairness: grants 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b11;
      set_req(0, 32'hB000_0000 + k, 3'd1);
      set_req(1, 32'hB100_0000 + k, 3'd2);
      if (k % 2 == 0) exp_iss.push_back('{id: 4'b0001, instr: 32'hB000_0000 + k});
      else            exp_iss.push_back('{id: 4'b1010, instr: 32'hB100_0000 + k});
      @(negedge clk);
      check("t2_ready", {62'd0, req_ready}, (k % 2 == 0) ? 64'h1 : 64'h2);
      next_cycle();
    end

    // Move the pointer to 1 so the stall must rely on the lock.
    req_valid = 2'b01;
    set_req(0, 32'hD000_0000, 3'd6);
    exp_iss.push_back('{id: 4'b0110, instr: 32'hD000_0000});
    next_cycle();

    // 3. Stall with req1 rising: grant held on req0.
    req_valid = 2'b01;
    cop_ready = 1'b0;
    set_req(0, 32'hC000_0000, 3'd3);
    set_req(1, 32'hC100_0000, 3'd4);
    @(negedge clk);
    check("t3_cop_valid", {63'd0, cop_valid}, 64'h1);
    check("t3_ready_stall", {62'd0, req_ready}, 64'h0);
    check("t3_id_first", {60'd0, cop_id}, 64'h3);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      req_valid = 2'b11;
      @(negedge clk);
      check("t3_hold_id", {60'd0, cop_id}, 64'h3);
      check("t3_hold_instr", {32'd0, cop_instr}, 64'hC000_0000);
      next_cycle();
    end
    cop_ready = 1'b1;
    exp_iss.push_back('{id: 4'b0011, instr: 32'hC000_0000});
    @(negedge clk);
    check("t3_release_ready", {62'd0, req_ready}, 64'h1);
    next_cycle();
    req_valid = 2'b10;
    exp_iss.push_back('{id: 4'b1100, instr: 32'hC100_0000});
    @(negedge clk);
    check("t3_req1_ready", {62'd0, req_ready}, 64'h2);
    next_cycle();

    // 4. Outstanding limit on req0.
    cop_wb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_valid = 2'b01;
      set_req(0, 32'hE000_0000 + k, 3'(k));
      exp_iss.push_back('{id: {1'b0, 3'(k)}, instr: 32'hE000_0000 + k});
      @(negedge clk);
      check("t4_fill_ready", {62'd0, req_ready}, 64'h1);
      next_cycle();
    end
    cop_wb = 1'b0;
    req_valid = 2'b11;
    set_req(1, 32'hE100_0000, 3'd7);
    exp_iss.push_back('{id: 4'b1111, instr: 32'hE100_0000});
    @(negedge clk);
    check("t4_req1_served", {62'd0, req_ready}, 64'h2);
    next_cycle();
    req_valid = 2'b01;
    @(negedge clk);
    check("t4_masked_valid", {63'd0, cop_valid}, 64'h0);
    check("t4_masked_ready", {62'd0, req_ready}, 64'h0);
    next_cycle();
    req_valid = 2'b00;
    cop_res_valid = 1'b1;
    cop_res_id = 4'b0010;
    cop_res_data = 64'h1234_5678_9ABC_DEF0;
    exp_res.push_back('{vld: 2'b01, id: 3'd2, data: 64'h1234_5678_9ABC_DEF0});
    next_cycle();
    cop_res_valid = 1'b0;
    req_valid = 2'b01;
    set_req(0, 32'hF000_0000, 3'd1);
    exp_iss.push_back('{id: 4'b0001, instr: 32'hF000_0000});
    @(negedge clk);
    check("t4_reenabled_ready", {62'd0, req_ready}, 64'h1);
    next_cycle();

    // 5. Simultaneous wb accept and result on req1: count stays at 1.
    req_valid = 2'b10;
    cop_wb = 1'b1;
    set_req(1, 32'h6100_0001, 3'd2);
    exp_iss.push_back('{id: 4'b1010, instr: 32'h6100_0001});
    next_cycle();
    set_req(1, 32'h6100_0002, 3'd3);
    exp_iss.push_back('{id: 4'b1011, instr: 32'h6100_0002});
    cop_res_valid = 1'b1;
    cop_res_id = 4'b1010;
    cop_res_data = 64'hAAAA_0000_0000_0001;
    exp_res.push_back('{vld: 2'b10, id: 3'd2, data: 64'hAAAA_0000_0000_0001});
    @(negedge clk);
    check("t5_ready", {62'd0, req_ready}, 64'h2);
    next_cycle();
    req_valid = 2'b00;
    cop_wb = 1'b0;
    cop_res_id = 4'b1011;
    cop_res_data = 64'hAAAA_0000_0000_0002;
    exp_res.push_back('{vld: 2'b10, id: 3'd3, data: 64'hAAAA_0000_0000_0002});
    next_cycle();

    // 6. Result for req1 with nothing outstanding.
    cop_res_id = 4'b1101;
    cop_res_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check("t6_res_valid", {62'd0, res_valid}, 64'h0);
    check("t6_err_before", {63'd0, err}, 64'h0);
    next_cycle();
    cop_res_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_err_sticky", {63'd0, err}, 64'h1);
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("t6_err_cleared", {63'd0, err}, 64'h0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    check("iss_queue_empty", 64'(exp_iss.size()), 64'd0);
    check("res_queue_empty", 64'(exp_res.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
